mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
//  Multicycle MIPS control FSM; the initiator side of the ALU control interface and of the register-file write port.
//  Sequences fetch/decode/execute/memory/writeback, one state per clock.
//  Drives 5-bit ALU control codes, datapath mux selects and write enables.
//  Sits between the instruction register and the shared datapath.
// PARAMETERS
//  OPCODE_WIDTH  6  instruction[31:26] width
//  FUNCT_WIDTH   6  instruction[5:0] width
//  CTRL_WIDTH    5  ALU control width: {invA, invB, op[2:0]}
// PORTS
//  clock       in   1  single clock; all state changes on rising edge
//  reset       in   1  synchronous, active-high; sampled on rising clock edge
//  opcode      in   6  IR[31:26]; valid from DECODE onward
//  funct       in   6  IR[5:0]
//  aluZero     in   1  datapath flag: ALU result == 0
//  aluControl  out  5  ALU operation code
//  aluCarryIn  out  1  drives ALU statusIn carry bit; constant 0
//  aluSrcA     out  1  0 = PC, 1 = regA
//  aluSrcB     out  2  0 = regB, 1 = const 4, 2 = signext imm, 3 = signext imm << 2
//  iorD        out  1  memory address: 0 = PC, 1 = ALUOut
//  memRead     out  1  memory read strobe
//  memWrite    out  1  memory write strobe
//  irWrite     out  1  load instruction register
//  regDst      out  1  write address: 0 = rt, 1 = rd
//  memToReg    out  1  write data: 0 = ALUOut, 1 = MDR
//  regWrite    out  1  register file write enable
//  pcWrite     out  1  PC load (unconditional, or beq with aluZero)
//  pcSource    out  2  0 = ALU, 1 = ALUOut, 2 = jump target
//  illegalOp   out  1  one-cycle pulse on unsupported opcode or funct
//  state       out  4  current state, for debug
// BEHAVIOUR
//  ALU codes: AND=00000, OR=00001, ADD=00010, SUB=01010, SLT=01011, NOR=11000.
//  States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, BEQ, ADDIEX, ADDIWB, JUMP.
//  Outputs are Moore, decoded from state only, except pcWrite in BEQ (= aluZero).
//  Every output not listed for a state is 0.
//  FETCH:
//   memRead=1, irWrite=1, aluSrcA=0, aluSrcB=1, ADD, pcSource=0, pcWrite=1
//   -> DECODE
//  DECODE:
//   aluSrcA=0, aluSrcB=3, ADD (branch target into ALUOut)
//   next state by opcode: lw/sw -> MEMADR; R(000000) -> RTEXE; beq(000100) -> BEQ;
//   addi(001000) -> ADDIEX; j(000010) -> JUMP
//   any other opcode -> FETCH with illegalOp=1 for this cycle
//  MEMADR:
//   aluSrcA=1, aluSrcB=2, ADD
//   lw(100011) -> MEMRD; sw(101011) -> MEMWR
//  MEMRD:  memRead=1, iorD=1 -> MEMWB
//  MEMWB:  regWrite=1, memToReg=1, regDst=0 -> FETCH
//  MEMWR:  memWrite=1, iorD=1 -> FETCH
//  RTEXE:
//   aluSrcA=1, aluSrcB=0
//   funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR
//   unknown funct: illegalOp=1, aluControl=AND, -> FETCH, no writeback
//   known funct -> RTWB
//  RTWB:
//   regWrite=1, regDst=1, memToReg=0
//   aluControl holds the RTEXE code -> FETCH
//  BEQ:
//   aluSrcA=1, aluSrcB=0, SUB, pcSource=1, pcWrite=aluZero -> FETCH
//  ADDIEX: aluSrcA=1, aluSrcB=2, ADD -> ADDIWB
//  ADDIWB: regWrite=1, regDst=0, memToReg=0 -> FETCH
//  JUMP:   pcSource=2, pcWrite=1 -> FETCH
//  Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
//  Reset:
//   state=FETCH, so outputs show FETCH values during reset
//   reset has priority over every transition, including mid-instruction
//   the next edge after reset deasserts executes FETCH
//  aluCarryIn is 0 in all states; ADD must not add a stale carry.
//  opcode/funct are sampled only in DECODE/MEMADR/RTEXE; IR changes elsewhere are ignored.
//  No write enable (regWrite, memWrite, pcWrite, irWrite) is asserted in the cycle illegalOp pulses.
// STRUCTURE
//  Shared package:
//   opcode and funct constants
//   ALU control codes (AND..NOR, with the SLL/SRL codes reserved)
//   state encoding (4-bit)
//  Sub-module alu_control_decode: combinational funct -> {aluControl, illegal}, reused by RTEXE/RTWB.
//  Remaining logic: state register plus a next-state/output case.
// TESTING
//  1. Reset held 3 cycles mid-lw (in MEMRD) -> state=FETCH, memRead=1, irWrite=1, regWrite=0; FETCH next edge.
//  2. lw (op 100011) -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regWrite only in cycle 5, memToReg=1.
//  3. R-type sub (funct 100010) -> aluControl=01010 in RTEXE and RTWB, regDst=1, regWrite in cycle 4.
//  4. beq with aluZero=1 then aluZero=0 -> pcWrite=1/0 in BEQ, pcSource=1, 3-cycle instruction.
//  5. opcode 111111 -> illegalOp pulse in DECODE, no write enables, FETCH next.
//     funct 000000 -> illegalOp in RTEXE, no RTWB.
//  6. Back-to-back addi,j,sw -> counts 4,3,4; aluCarryIn=0 throughout; pcSource=2 in JUMP.

Source files
------------

// File: rtl/mips_multicycle_control_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, functs,
// ALU control codes and the 4-bit FSM state encoding.
package mips_multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // {invA, invB, op[2:0]}; shift codes are reserved but not yet decoded
  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRL = 5'b00101;
  localparam logic [4:0] ALU_SUB = 5'b01010;
  localparam logic [4:0] ALU_SLT = 5'b01011;
  localparam logic [4:0] ALU_NOR = 5'b11000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

endpackage

// File: rtl/mips_multicycle_control_alu_decode.sv
// Combinational R-type funct decoder: funct -> ALU control code plus an
// illegal flag for unsupported functs (which decode to AND).
module alu_control_decode
  import mips_multicycle_control_pkg::*;
#(
  parameter int FUNCT_WIDTH = 6,
  parameter int CTRL_WIDTH  = 5
) (
  input  logic [FUNCT_WIDTH-1:0] funct,
  output logic [CTRL_WIDTH-1:0]  ctrl,
  output logic                   illegal
);

  always_comb begin
    ctrl    = ALU_AND;
    illegal = 1'b0;
    case (funct)
      FN_ADD:  ctrl = ALU_ADD;
      FN_SUB:  ctrl = ALU_SUB;
      FN_AND:  ctrl = ALU_AND;
      FN_OR:   ctrl = ALU_OR;
      FN_SLT:  ctrl = ALU_SLT;
      FN_NOR:  ctrl = ALU_NOR;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: one state per clock, Moore outputs except the
// beq PC write, which follows the datapath zero flag.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6,
  parameter int FUNCT_WIDTH  = 6,
  parameter int CTRL_WIDTH   = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [FUNCT_WIDTH-1:0]  funct,
  input  logic                    aluZero,
  output logic [CTRL_WIDTH-1:0]   aluControl,
  output logic                    aluCarryIn,
  output logic                    aluSrcA,
  output logic [1:0]              aluSrcB,
  output logic                    iorD,
  output logic                    memRead,
  output logic                    memWrite,
  output logic                    irWrite,
  output logic                    regDst,
  output logic                    memToReg,
  output logic                    regWrite,
  output logic                    pcWrite,
  output logic [1:0]              pcSource,
  output logic                    illegalOp,
  output logic [3:0]              state
);

  state_t                state_q, state_d;
  logic [CTRL_WIDTH-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [CTRL_WIDTH-1:0] dec_ctrl;
  logic                  dec_illegal;

  alu_control_decode #(
    .FUNCT_WIDTH (FUNCT_WIDTH),
    .CTRL_WIDTH  (CTRL_WIDTH)
  ) u_alu_dec (
    .funct   (funct),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_FETCH;
      alu_ctrl_q <= ALU_AND;
    end else begin
      state_q    <= state_d;
      alu_ctrl_q <= alu_ctrl_d;
    end
  end

  assign state      = state_q;
  assign aluCarryIn = 1'b0;

  always_comb begin
    state_d    = state_q;
    alu_ctrl_d = alu_ctrl_q;
    aluControl = ALU_AND;
    aluSrcA    = 1'b0;
    aluSrcB    = 2'd0;
    iorD       = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    irWrite    = 1'b0;
    regDst     = 1'b0;
    memToReg   = 1'b0;
    regWrite   = 1'b0;
    pcWrite    = 1'b0;
    pcSource   = 2'd0;
    illegalOp  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memRead    = 1'b1;
        irWrite    = 1'b1;
        aluSrcB    = 2'd1;
        aluControl = ALU_ADD;
        pcWrite    = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        aluSrcB    = 2'd3;
        aluControl = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTEXE;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegalOp = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA    = 1'b1;
        aluSrcB    = 2'd2;
        aluControl = ALU_ADD;
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        state_d  = S_FETCH;
      end
      S_RTEXE: begin
        aluSrcA = 1'b1;
        if (dec_illegal) begin
          illegalOp = 1'b1;
          state_d   = S_FETCH;
        end else begin
          // Capture the code so RTWB is immune to later IR changes
          aluControl = dec_ctrl;
          alu_ctrl_d = dec_ctrl;
          state_d    = S_RTWB;
        end
      end
      S_RTWB: begin
        aluControl = alu_ctrl_q;
        regWrite   = 1'b1;
        regDst     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        aluSrcA    = 1'b1;
        aluControl = ALU_SUB;
        pcSource   = 2'd1;
        pcWrite    = aluZero;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        aluSrcA    = 1'b1;
        aluSrcB    = 2'd2;
        aluControl = ALU_ADD;
        state_d    = S_ADDIWB;
      end
      S_ADDIWB: begin
        regWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcSource = 2'd2;
        pcWrite  = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for the multicycle control FSM: directed instruction
// sequences push expected per-cycle output vectors, a monitor compares them.
module tb_mips_multicycle_control;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                         MEMWB = 4'd4, MEMWR = 4'd5, RTEXE = 4'd6, RTWB = 4'd7,
                         BEQ = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11;
  localparam logic [4:0] C_AND = 5'b00000, C_OR = 5'b00001, C_ADD = 5'b00010,
                         C_SUB = 5'b01010, C_SLT = 5'b01011, C_NOR = 5'b11000;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BQ = 6'b000100, ADDI = 6'b001000, JJ = 6'b000010;

  typedef struct packed {
    logic [3:0] st;
    logic [4:0] alu;
    logic       cin;
    logic       srcA;
    logic [1:0] srcB;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       pcWrite;
    logic [1:0] pcSrc;
    logic       ill;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       aluZero;
  logic [4:0] aluControl;
  logic       aluCarryIn, aluSrcA, iorD, memRead, memWrite, irWrite;
  logic       regDst, memToReg, regWrite, pcWrite, illegalOp;
  logic [1:0] aluSrcB, pcSource;
  logic [3:0] state;

  vec_t  exp_q[$];
  string name_q[$];
  string phase;
  int    vectors = 0;
  int    miscompares = 0;
  vec_t  act;

  always #5 clock = ~clock;

  mips_multicycle_control #(
    .OPCODE_WIDTH (6),
    .FUNCT_WIDTH  (6),
    .CTRL_WIDTH   (5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .aluZero    (aluZero),
    .aluControl (aluControl),
    .aluCarryIn (aluCarryIn),
    .aluSrcA    (aluSrcA),
    .aluSrcB    (aluSrcB),
    .iorD       (iorD),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .irWrite    (irWrite),
    .regDst     (regDst),
    .memToReg   (memToReg),
    .regWrite   (regWrite),
    .pcWrite    (pcWrite),
    .pcSource   (pcSource),
    .illegalOp  (illegalOp),
    .state      (state)
  );

  assign act = {state, aluControl, aluCarryIn, aluSrcA, aluSrcB, iorD, memRead,
                memWrite, irWrite, regDst, memToReg, regWrite, pcWrite, pcSource,
                illegalOp};

  // Output table per state, transcribed from the state descriptions
  function automatic vec_t exp_of(input logic [3:0] s, input logic [4:0] code,
                                  input logic z, input logic ill);
    vec_t v;
    v    = '0;
    v.st = s;
    case (s)
      FETCH:  begin v.memRead = 1; v.irWrite = 1; v.srcB = 2'd1; v.alu = C_ADD; v.pcWrite = 1; end
      DECODE: begin v.srcB = 2'd3; v.alu = C_ADD; v.ill = ill; end
      MEMADR: begin v.srcA = 1; v.srcB = 2'd2; v.alu = C_ADD; end
      MEMRD:  begin v.memRead = 1; v.iorD = 1; end
      MEMWB:  begin v.regWrite = 1; v.memToReg = 1; end
      MEMWR:  begin v.memWrite = 1; v.iorD = 1; end
      RTEXE:  begin v.srcA = 1; v.alu = code; v.ill = ill; end
      RTWB:   begin v.regWrite = 1; v.regDst = 1; v.alu = code; end
      BEQ:    begin v.srcA = 1; v.alu = C_SUB; v.pcSrc = 2'd1; v.pcWrite = z; end
      ADDIEX: begin v.srcA = 1; v.srcB = 2'd2; v.alu = C_ADD; end
      ADDIWB: begin v.regWrite = 1; end
      JUMP:   begin v.pcSrc = 2'd2; v.pcWrite = 1; end
      default: ;
    endcase
    return v;
  endfunction

  // One clock cycle: drive inputs for the state the DUT should be in now
  task automatic cyc(input logic [3:0] s, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rst, input logic [4:0] code,
                     input logic ill);
    opcode  = op;
    funct   = fn;
    aluZero = z;
    reset   = rst;
    exp_q.push_back(exp_of(s, code, z, ill));
    name_q.push_back(phase);
    @(posedge clock);
    #1;
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [4:0] code);
    cyc(FETCH,  6'b111111, 6'b000000, 0, 0, C_AND, 0);
    cyc(DECODE, RT, fn, 0, 0, C_AND, 0);
    cyc(RTEXE,  RT, fn, 0, 0, code, 0);
    cyc(RTWB,   6'b111111, 6'b000000, 0, 0, code, 0);
  endtask

  initial begin : monitor
    vec_t  e;
    string n;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL %s t=%0t: got st=%0d alu=%b vec=%h, expected st=%0d alu=%b vec=%h",
                   n, $time, act.st, act.alu, act, e.st, e.alu, e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset = 1; opcode = '0; funct = '0; aluZero = 0;
    repeat (2) @(posedge clock);
    #1;

    phase = "reset_state";
    cyc(FETCH, LW, 6'd0, 0, 1, C_AND, 0);

    phase = "reset_mid_lw";
    cyc(FETCH,  LW, 6'd0, 0, 0, C_AND, 0);
    cyc(DECODE, LW, 6'd0, 0, 0, C_AND, 0);
    cyc(MEMADR, LW, 6'd0, 0, 0, C_AND, 0);
    cyc(MEMRD,  LW, 6'd0, 0, 1, C_AND, 0);
    cyc(FETCH,  LW, 6'd0, 0, 1, C_AND, 0);
    cyc(FETCH,  LW, 6'd0, 0, 1, C_AND, 0);
    cyc(FETCH,  LW, 6'd0, 0, 0, C_AND, 0);
    cyc(DECODE, JJ, 6'd0, 0, 0, C_AND, 0);
    cyc(JUMP,   JJ, 6'd0, 0, 0, C_AND, 0);

    phase = "lw";
    cyc(FETCH,  LW, 6'd0, 0, 0, C_AND, 0);
    cyc(DECODE, LW, 6'd0, 0, 0, C_AND, 0);
    cyc(MEMADR, LW, 6'd0, 0, 0, C_AND, 0);
    cyc(MEMRD,  SW, 6'd0, 0, 0, C_AND, 0);
    cyc(MEMWB,  6'b111111, 6'd0, 0, 0, C_AND, 0);

    phase = "rtype_sub";  rtype(6'b100010, C_SUB);
    phase = "rtype_add";  rtype(6'b100000, C_ADD);
    phase = "rtype_and";  rtype(6'b100100, C_AND);
    phase = "rtype_or";   rtype(6'b100101, C_OR);
    phase = "rtype_slt";  rtype(6'b101010, C_SLT);
    phase = "rtype_nor";  rtype(6'b100111, C_NOR);

    phase = "beq_taken";
    cyc(FETCH,  BQ, 6'd0, 1, 0, C_AND, 0);
    cyc(DECODE, BQ, 6'd0, 1, 0, C_AND, 0);
    cyc(BEQ,    BQ, 6'd0, 1, 0, C_AND, 0);
    phase = "beq_not_taken";
    cyc(FETCH,  BQ, 6'd0, 0, 0, C_AND, 0);
    cyc(DECODE, BQ, 6'd0, 0, 0, C_AND, 0);
    cyc(BEQ,    BQ, 6'd0, 0, 0, C_AND, 0);

    phase = "illegal_opcode";
    cyc(FETCH,  6'b111111, 6'd0, 0, 0, C_AND, 0);
    cyc(DECODE, 6'b111111, 6'd0, 0, 0, C_AND, 1);
    phase = "illegal_funct";
    cyc(FETCH,  RT, 6'b000000, 0, 0, C_AND, 0);
    cyc(DECODE, RT, 6'b000000, 0, 0, C_AND, 0);
    cyc(RTEXE,  RT, 6'b000000, 0, 0, C_AND, 1);

    phase = "addi";
    cyc(FETCH,  ADDI, 6'd0, 0, 0, C_AND, 0);
    cyc(DECODE, ADDI, 6'd0, 0, 0, C_AND, 0);
    cyc(ADDIEX, ADDI, 6'd0, 0, 0, C_AND, 0);
    cyc(ADDIWB, ADDI, 6'd0, 0, 0, C_AND, 0);
    phase = "jump";
    cyc(FETCH,  JJ, 6'd0, 0, 0, C_AND, 0);
    cyc(DECODE, JJ, 6'd0, 0, 0, C_AND, 0);
    cyc(JUMP,   LW, 6'd0, 0, 0, C_AND, 0);
    phase = "sw";
    cyc(FETCH,  SW, 6'd0, 0, 0, C_AND, 0);
    cyc(DECODE, SW, 6'd0, 0, 0, C_AND, 0);
    cyc(MEMADR, SW, 6'd0, 0, 0, C_AND, 0);
    cyc(MEMWR,  LW, 6'd0, 0, 0, C_AND, 0);
    phase = "after_sw";
    cyc(FETCH,  RT, 6'd0, 0, 0, C_AND, 0);

    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
